// File: rtl/draw_circle.sv
// Circle-outline drawing controller: sequences a circle distance generator and
// emits the four quadrant pixels of each generated step under oe flow control.

module circle #(
  parameter int CORDW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    oe,
  input  logic signed [CORDW-1:0] r0,
  output logic signed [CORDW-1:0] xa,
  output logic signed [CORDW-1:0] ya,
  output logic                    valid,
  output logic                    done
);

  localparam int EW = CORDW + 2;
  localparam logic signed [EW-1:0]    TWO   = 2;
  localparam logic signed [EW-1:0]    THREE = 3;
  localparam logic signed [CORDW-1:0] ONE   = 1;

  typedef enum logic [2:0] {C_IDLE, C_VALID, C_WAIT, C_CALC_Y, C_CALC_X} cState_t;

  cState_t                 r_state;
  logic signed [CORDW-1:0] r_xa, r_ya;
  logic signed [EW-1:0]    r_err, r_errTmp;
  logic                    r_done;
  logic signed [EW-1:0]    w_r0Ext, w_xaExt, w_yaExt;

  assign w_r0Ext = {{2{r0[CORDW-1]}}, r0};
  assign w_xaExt = {{2{r_xa[CORDW-1]}}, r_xa};
  assign w_yaExt = {{2{r_ya[CORDW-1]}}, r_ya};

  // Midpoint error walk from (-r, 0) towards the y axis; the y step is decided
  // on the old error and the x step on both the old and the updated error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= C_IDLE;
      r_xa     <= '0;
      r_ya     <= '0;
      r_err    <= '0;
      r_errTmp <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        C_IDLE: begin
          if (start) begin
            r_xa    <= -r0;
            r_ya    <= '0;
            r_err   <= TWO - (w_r0Ext <<< 1);
            r_state <= C_VALID;
          end
        end
        C_VALID:  if (oe) r_state <= C_WAIT;
        C_WAIT:   r_state <= C_CALC_Y;
        C_CALC_Y: begin
          if (r_xa == '0) begin
            r_state <= C_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_errTmp <= r_err;
            if (r_err <= w_yaExt) begin
              r_ya  <= r_ya + ONE;
              r_err <= r_err + (w_yaExt <<< 1) + THREE;
            end
            r_state <= C_CALC_X;
          end
        end
        C_CALC_X: begin
          if ((r_errTmp > w_xaExt) || (r_err > w_yaExt)) begin
            r_xa  <= r_xa + ONE;
            r_err <= r_err + (w_xaExt <<< 1) + THREE;
          end
          r_state <= C_VALID;
        end
        default: r_state <= C_IDLE;
      endcase
    end
  end

  assign xa    = r_xa;
  assign ya    = r_ya;
  assign valid = (r_state == C_VALID);
  assign done  = r_done;

endmodule

module draw_circle #(
  parameter int CORDW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    oe,
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] y0,
  input  logic signed [CORDW-1:0] r0,
  output logic signed [CORDW-1:0] x,
  output logic signed [CORDW-1:0] y,
  output logic                    drawing,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_PT, S_DRAW, S_NEXT, S_DONE} state_t;

  state_t                  r_state, w_next;
  logic signed [CORDW-1:0] r_xc, r_yc, r_r0, r_xs, r_ys;
  logic [1:0]              r_q;
  logic                    r_busy, r_done, r_cStart, r_cOe;
  logic signed [CORDW-1:0] w_cXa, w_cYa;
  logic                    w_cValid, w_cDone;
  logic                    w_accept, w_finish, w_lastPix;

  circle #(.CORDW(CORDW)) u_circle (
    .clk   (clk),
    .rst   (rst),
    .start (r_cStart),
    .oe    (r_cOe),
    .r0    (r_r0),
    .xa    (w_cXa),
    .ya    (w_cYa),
    .valid (w_cValid),
    .done  (w_cDone)
  );

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_finish  = (r_state == S_WAIT_PT) && !w_cValid && w_cDone;
  assign w_lastPix = (r_state == S_DRAW) && oe && (r_q == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_WAIT_PT;
      S_WAIT_PT: begin
        if (w_cValid)     w_next = S_DRAW;
        else if (w_cDone) w_next = S_DONE;
      end
      S_DRAW:    if (oe && (r_q == 2'd3)) w_next = S_NEXT;
      S_NEXT:    w_next = S_WAIT_PT;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // The radius is held locally because the generator samples it one edge after start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xc     <= '0;
      r_yc     <= '0;
      r_r0     <= '0;
      r_xs     <= '0;
      r_ys     <= '0;
      r_q      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cStart <= 1'b0;
      r_cOe    <= 1'b0;
    end else begin
      r_cStart <= w_accept;
      r_cOe    <= w_lastPix;
      r_done   <= w_finish;
      if (w_accept) begin
        r_xc   <= x0;
        r_yc   <= y0;
        r_r0   <= r0;
        r_busy <= 1'b1;
      end else if (w_finish) begin
        r_busy <= 1'b0;
      end
      if ((r_state == S_WAIT_PT) && w_cValid) begin
        r_xs <= w_cXa;
        r_ys <= w_cYa;
        r_q  <= '0;
      end else if ((r_state == S_DRAW) && oe) begin
        r_q <= r_q + 2'd1;
      end
    end
  end

  always_comb begin
    drawing = (r_state == S_DRAW) && oe;
    busy    = r_busy;
    done    = r_done;
    x       = '0;
    y       = '0;
    case (r_q)
      2'd0: begin x = r_xc - r_xs; y = r_yc + r_ys; end
      2'd1: begin x = r_xc - r_ys; y = r_yc - r_xs; end
      2'd2: begin x = r_xc + r_xs; y = r_yc - r_ys; end
      default: begin x = r_xc + r_ys; y = r_yc + r_xs; end
    endcase
  end

endmodule

// File: tb/tb_draw_circle.sv
// Self-checking bench for draw_circle: table-driven circles against a loop-based
// midpoint model, plus reset, start-while-busy and 8-bit wrap sequences.

module tb_draw_circle;

  logic               clk = 1'b0;
  logic               rst;
  logic               start, oe;
  logic signed [15:0] x0, y0, r0, x, y;
  logic               drawing, busy, done;

  logic              start8, oe8;
  logic signed [7:0] x0_8, y0_8, r0_8, x8, y8;
  logic              drawing8, busy8, done8;

  int nCompared = 0;
  int nMismatched = 0;
  int expX[$], expY[$], obsX[$], obsY[$];

  typedef struct {
    int cx; int cy; int r; bit oeRand; bit timing; int eFx; int eFy;
  } vec_t;
  vec_t vecs[9];

  draw_circle #(.CORDW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .oe(oe), .x0(x0), .y0(y0), .r0(r0),
    .x(x), .y(y), .drawing(drawing), .busy(busy), .done(done)
  );

  draw_circle #(.CORDW(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .oe(oe8), .x0(x0_8), .y0(y0_8), .r0(r0_8),
    .x(x8), .y(y8), .drawing(drawing8), .busy(busy8), .done(done8)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = 16'(v);
    return int'(t);
  endfunction

  task automatic pushPix(input int px, input int py);
    expX.push_back(wrap16(px));
    expY.push_back(wrap16(py));
  endtask

  // Midpoint circle walk from (-r,0) until the step that reaches the y axis.
  task automatic buildModel(input int cx, input int cy, input int r);
    int xs, ys, err, rr;
    expX.delete(); expY.delete();
    xs = -r; ys = 0; err = 2 - 2 * r;
    forever begin
      pushPix(cx - xs, cy + ys);
      pushPix(cx - ys, cy - xs);
      pushPix(cx + xs, cy - ys);
      pushPix(cx + ys, cy + xs);
      if (xs == 0) break;
      rr = err;
      if (rr <= ys) begin ys++; err += 2 * ys + 1; end
      if (rr > xs || err > ys) begin xs++; err += 2 * xs + 1; end
    end
  endtask

  task automatic applyStimulus(input int cx, input int cy, input int r);
    @(posedge clk); #1;
    x0 = 16'(cx); y0 = 16'(cy); r0 = 16'(r);
    start = 1'b1; oe = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic runCircle(input int cx, input int cy, input int r, input bit oeRand,
                           input bit timing, input int injectAt, input int resetAt,
                           output bit aborted);
    int nPix, firstS, lastS, doneS, busyBad, d;
    bit doneSeen, injected;
    buildModel(cx, cy, r);
    obsX.delete(); obsY.delete();
    nPix = 0; firstS = -1; lastS = -1; doneS = -1; busyBad = 0;
    doneSeen = 0; injected = 0; aborted = 0;
    applyStimulus(cx, cy, r);
    for (int s = 0; s < 3000; s++) begin
      start = 1'b0;
      oe = oeRand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (resetAt >= 0 && nPix == resetAt) begin
        rst = 1'b1;
        #1;
        checkOutput("reset x", int'(x), 0);
        checkOutput("reset y", int'(y), 0);
        checkOutput("reset drawing", int'(drawing), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        aborted = 1;
        break;
      end
      if (injectAt >= 0 && nPix == injectAt && !injected) begin
        injected = 1;
        start = 1'b1; x0 = 16'sd555; y0 = -16'sd66; r0 = 16'sd5;
      end
      #1;
      if (drawing) begin
        if (nPix == 0) firstS = s;
        lastS = s;
        obsX.push_back(int'(x)); obsY.push_back(int'(y));
        if (nPix < expX.size()) begin
          checkOutput($sformatf("pixel %0d x", nPix), int'(x), expX[nPix]);
          checkOutput($sformatf("pixel %0d y", nPix), int'(y), expY[nPix]);
        end
        if (r == 20) begin
          d = (int'(x) - cx) * (int'(x) - cx) + (int'(y) - cy) * (int'(y) - cy) - 400;
          checkOutput("radius tolerance", int'(d >= -40 && d <= 40), 1);
        end
        nPix++;
      end else if (oeRand && (nPix % 4) != 0 && nPix < expX.size()) begin
        checkOutput("stall hold x", int'(x), expX[nPix]);
        checkOutput("stall hold y", int'(y), expY[nPix]);
      end
      if (done) begin
        doneSeen = 1; doneS = s;
        checkOutput("busy low at done", int'(busy), 0);
        checkOutput("done with drawing", int'(drawing), 0);
        break;
      end
      if (!busy) busyBad++;
      @(posedge clk); #1;
    end
    if (aborted) return;
    checkOutput("done seen", int'(doneSeen), 1);
    checkOutput("pixel count", nPix, expX.size());
    checkOutput("busy during draw", busyBad, 0);
    if (timing) begin
      checkOutput("first pixel latency", firstS, 2);
      checkOutput("last pixel to done", doneS - lastS, 5);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput("done single pulse", int'(done), 0);
      checkOutput("busy idle", int'(busy), 0);
    end
  endtask

  task automatic checkR1();
    int ex[8];
    int ey[8];
    ex = '{1, 0, -1, 0, 0, -1, 0, 1};
    ey = '{0, 1, 0, -1, 1, 0, -1, 0};
    checkOutput("r1 count", obsX.size(), 8);
    for (int k = 0; k < 8 && k < obsX.size(); k++) begin
      checkOutput($sformatf("r1 pix %0d x", k), obsX[k], ex[k]);
      checkOutput($sformatf("r1 pix %0d y", k), obsY[k], ey[k]);
    end
  endtask

  initial begin
    bit ab, found;
    int rc;
    rst = 1'b1; start = 1'b0; oe = 1'b1; x0 = '0; y0 = '0; r0 = '0;
    start8 = 1'b0; oe8 = 1'b1; x0_8 = '0; y0_8 = '0; r0_8 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("init x", int'(x), 0);
    checkOutput("init y", int'(y), 0);
    checkOutput("init drawing", int'(drawing), 0);
    checkOutput("init busy", int'(busy), 0);
    checkOutput("init done", int'(done), 0);
    rst = 1'b0;

    vecs[0] = '{cx: 0,     cy: 0,  r: 1,  oeRand: 0, timing: 1, eFx: 1,      eFy: 0};
    vecs[1] = '{cx: 10,    cy: 10, r: 0,  oeRand: 0, timing: 1, eFx: 10,     eFy: 10};
    vecs[2] = '{cx: 100,   cy: 50, r: 20, oeRand: 0, timing: 1, eFx: 120,    eFy: 50};
    vecs[3] = '{cx: 100,   cy: 50, r: 20, oeRand: 1, timing: 0, eFx: 120,    eFy: 50};
    vecs[4] = '{cx: -5,    cy: 7,  r: 3,  oeRand: 1, timing: 0, eFx: -2,     eFy: 7};
    vecs[5] = '{cx: 32760, cy: 0,  r: 10, oeRand: 0, timing: 1, eFx: -32766, eFy: 0};
    for (int i = 6; i < 9; i++) begin
      vecs[i].cx = $urandom_range(0, 2000) - 1000;
      vecs[i].cy = $urandom_range(0, 2000) - 1000;
      vecs[i].r = $urandom_range(0, 40);
      vecs[i].oeRand = 1; vecs[i].timing = 0;
      vecs[i].eFx = vecs[i].cx + vecs[i].r; vecs[i].eFy = vecs[i].cy;
    end

    for (int i = 0; i < 9; i++) begin
      runCircle(vecs[i].cx, vecs[i].cy, vecs[i].r, vecs[i].oeRand, vecs[i].timing, -1, -1, ab);
      checkOutput($sformatf("vec %0d has pixels", i), int'(obsX.size() > 0), 1);
      if (obsX.size() > 0) begin
        checkOutput($sformatf("vec %0d first x", i), obsX[0], vecs[i].eFx);
        checkOutput($sformatf("vec %0d first y", i), obsY[0], vecs[i].eFy);
      end
      if (i == 0) checkR1();
    end

    $display("[TB] reset during third group");
    runCircle(100, 50, 20, 0, 0, -1, 9, ab);
    checkOutput("reset path taken", int'(ab), 1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checkOutput("no done under reset", int'(done), 0);
    end
    rst = 1'b0;
    runCircle(0, 0, 1, 0, 1, -1, -1, ab);
    checkR1();

    $display("[TB] start while busy");
    runCircle(20, 30, 3, 0, 1, 2, -1, ab);

    $display("[TB] 8-bit wrap");
    @(posedge clk); #1;
    x0_8 = 8'sd120; y0_8 = 8'sd0; r0_8 = 8'sd20; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (drawing8) found = 1;
      else begin @(posedge clk); #1; end
    end
    checkOutput("cordw8 first pixel seen", int'(found), 1);
    if (found) begin
      checkOutput("cordw8 wrapped x", int'(x8), -116);
      checkOutput("cordw8 y", int'(y8), 0);
    end
    found = 0; rc = 0;
    for (int k = 0; k < 3000 && !found; k++) begin
      @(posedge clk); #1;
      if (done8) found = 1;
    end
    checkOutput("cordw8 done", int'(found), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
